packet_dispatcher: RTL and testbench

//  Reader at the downstream end of the packet queue: accepts one packet at a time on the

---
 rtl/packet_dispatcher_pkg.sv | 36 +++
 rtl/packet_dispatcher_if.sv | 13 +
 rtl/dispatch_send_port.sv | 52 +++++
 rtl/packet_dispatcher.sv | 128 ++++++++++++
 tb/tb_packet_dispatcher.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_dispatcher_pkg.sv
// Shared constants, state encodings and the destination decode for packet_dispatcher.
// Optional statistics counters are enabled with PACKET_DISPATCH_STAT_EN.
package packet_dispatcher_pkg;

  localparam int DEFAULT_PACKET_WIDTH = 175;

  localparam logic [1:0] DEST_OUT0  = 2'd0;
  localparam logic [1:0] DEST_OUT1  = 2'd1;
  localparam logic [1:0] DEST_BCAST = 2'd2;
  localparam logic [1:0] DEST_DROP  = 2'd3;

  localparam logic [0:0] S_RECV = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  typedef struct packed {
    logic out1;
    logic out0;
  } pending_t;

  // Which outputs still owe a handshake for a freshly accepted packet.
  function automatic pending_t dest_to_pending(input logic [1:0] dest);
    pending_t p;
    p = '0;
    case (dest)
      DEST_OUT0:  p.out0 = 1'b1;
      DEST_OUT1:  p.out1 = 1'b1;
      DEST_BCAST: begin
        p.out0 = 1'b1;
        p.out1 = 1'b1;
      end
      default:    p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/packet_dispatcher_if.sv
// Valid/ready packet channel; master drives VALID/DATA, slave drives READY.
interface packet_dispatcher_if #(
  parameter int WIDTH = packet_dispatcher_pkg::DEFAULT_PACKET_WIDTH
);

  logic             VALID;
  logic [WIDTH-1:0] DATA;
  logic             READY;

  modport master (output VALID, output DATA, input READY);
  modport slave  (input VALID, input DATA, output READY);

endinterface

// File: rtl/dispatch_send_port.sv
// One output lane of packet_dispatcher: pending bit, registered VALID and the
// done flag the top-level FSM uses to leave the send state.
module dispatch_send_port (
  input  logic CLK,
  input  logic RST,
  input  logic load_i,
  input  logic load_pending_i,
  input  logic in_send_i,
  input  logic ready_i,
  output logic valid_o,
  output logic done_o
);

  logic pending_q, pending_d;
  logic valid_q, valid_d;
  logic handshake;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    pending_d = pending_q;
    valid_d   = valid_q;
    handshake = valid_q && ready_i;

    if (load_i) begin
      pending_d = load_pending_i;
    end else if (handshake) begin
      pending_d = 1'b0;
    end

    if (handshake) begin
      valid_d = 1'b0;
    end else if (in_send_i && pending_q) begin
      valid_d = 1'b1;
    end
  end

  // Done once nothing is owed after this edge; a non-pending lane is always done.
  assign done_o  = !pending_d;
  assign valid_o = valid_q;

  always_ff @(posedge CLK) begin
    // NOTE: state updates use non-blocking assignments so all flops sample together.
    if (RST) begin
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/packet_dispatcher.sv
// Accepts one packet at a time and forwards it to output 0, output 1, both, or
// nowhere based on a 2-bit destination field. Define PACKET_DISPATCH_STAT_EN for counters.
module packet_dispatcher
  import packet_dispatcher_pkg::*;
#(
  parameter int PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int DEST_LSB     = 0
) (
  input  logic                CLK,
  input  logic                RST,
  packet_dispatcher_if.slave  RECEIVE_PC,
  packet_dispatcher_if.master SEND0_PC,
  packet_dispatcher_if.master SEND1_PC
`ifdef PACKET_DISPATCH_STAT_EN
  ,
  output logic [31:0]         SENT0_COUNT,
  output logic [31:0]         SENT1_COUNT,
  output logic [31:0]         DROP_COUNT
`endif
);

  logic [0:0]              state_q, state_d;
  logic                    ready_q, ready_d;
  logic [PACKET_WIDTH-1:0] data_q, data_d;
  logic [1:0]              dest;
  pending_t                load_pending;
  logic                    accept;
  logic                    valid0, valid1;
  logic                    done0, done1;

  assign dest         = RECEIVE_PC.DATA[DEST_LSB +: 2];
  assign load_pending = dest_to_pending(dest);
  // ready_q is only ever high in S_RECV, so this is the receive transfer edge.
  assign accept       = RECEIVE_PC.VALID && ready_q;

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_RECV: begin
        ready_d = RECEIVE_PC.VALID && !ready_q;
        if (accept) begin
          data_d = RECEIVE_PC.DATA;
          if (load_pending != '0) begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (done0 && done1) begin
          state_d = S_RECV;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: the packet register is reset as well so every output reads 0 after reset.
    if (RST) begin
      state_q <= S_RECV;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  dispatch_send_port u_port0 (
    .CLK            (CLK),
    .RST            (RST),
    .load_i         (accept),
    .load_pending_i (load_pending.out0),
    .in_send_i      (state_q == S_SEND),
    .ready_i        (SEND0_PC.READY),
    .valid_o        (valid0),
    .done_o         (done0)
  );

  dispatch_send_port u_port1 (
    .CLK            (CLK),
    .RST            (RST),
    .load_i         (accept),
    .load_pending_i (load_pending.out1),
    .in_send_i      (state_q == S_SEND),
    .ready_i        (SEND1_PC.READY),
    .valid_o        (valid1),
    .done_o         (done1)
  );

  assign RECEIVE_PC.READY = ready_q;
  assign SEND0_PC.VALID   = valid0;
  assign SEND0_PC.DATA    = data_q;
  assign SEND1_PC.VALID   = valid1;
  assign SEND1_PC.DATA    = data_q;

`ifdef PACKET_DISPATCH_STAT_EN
  logic [31:0] sent0_count_q, sent0_count_d;
  logic [31:0] sent1_count_q, sent1_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    sent0_count_d = sent0_count_q + 32'(valid0 && SEND0_PC.READY);
    sent1_count_d = sent1_count_q + 32'(valid1 && SEND1_PC.READY);
    drop_count_d  = drop_count_q  + 32'(accept && (dest == DEST_DROP));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sent0_count_q <= '0;
      sent1_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      sent0_count_q <= sent0_count_d;
      sent1_count_q <= sent1_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign SENT0_COUNT = sent0_count_q;
  assign SENT1_COUNT = sent1_count_q;
  assign DROP_COUNT  = drop_count_q;
`endif

endmodule

// File: tb/tb_packet_dispatcher.sv
// Self-checking bench for packet_dispatcher: directed scenarios plus randomized
// traffic scored against per-output expected queues built from the destination rules.
module tb_packet_dispatcher;
  import packet_dispatcher_pkg::*;

  localparam int W       = DEFAULT_PACKET_WIDTH;
  localparam int DL      = 0;
  localparam int TIMEOUT = 200;

  typedef logic [W-1:0] pkt_t;

  logic clk = 1'b0;
  logic rst;
  bit   rand_rdy = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  packet_dispatcher_if #(.WIDTH(W)) rx_if ();
  packet_dispatcher_if #(.WIDTH(W)) s0_if ();
  packet_dispatcher_if #(.WIDTH(W)) s1_if ();

`ifdef PACKET_DISPATCH_STAT_EN
  logic [31:0] sent0_count, sent1_count, drop_count;
`endif

  packet_dispatcher #(.PACKET_WIDTH(W), .DEST_LSB(DL)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RECEIVE_PC (rx_if),
    .SEND0_PC   (s0_if),
    .SEND1_PC   (s1_if)
`ifdef PACKET_DISPATCH_STAT_EN
    ,
    .SENT0_COUNT(sent0_count),
    .SENT1_COUNT(sent1_count),
    .DROP_COUNT (drop_count)
`endif
  );

  // Passive monitor: logs every transfer together with the edge it completes on.
  pkt_t        obs0_q[$], obs1_q[$];
  int unsigned obs0_edge[$], obs1_edge[$], acc_edge[$];
  int unsigned vld0_cycles = 0, vld1_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (s0_if.VALID && s0_if.READY) begin
        obs0_q.push_back(s0_if.DATA);
        obs0_edge.push_back(cyc + 1);
      end
      if (s1_if.VALID && s1_if.READY) begin
        obs1_q.push_back(s1_if.DATA);
        obs1_edge.push_back(cyc + 1);
      end
      if (rx_if.VALID && rx_if.READY) acc_edge.push_back(cyc + 1);
      if (s0_if.VALID) vld0_cycles++;
      if (s1_if.VALID) vld1_cycles++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      s0_if.READY = 1'($urandom_range(0, 1));
      s1_if.READY = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic pkt_t rand_pkt(input logic [1:0] dest);
    logic [191:0] r;
    pkt_t         p;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    p = r[W-1:0];
    p[DL +: 2] = dest;
    return p;
  endfunction

  // Presents a packet and holds VALID until the accept edge has passed.
  task automatic send_pkt(input pkt_t d);
    bit ok;
    ok = 1'b0;
    rx_if.VALID = 1'b1;
    rx_if.DATA  = d;
    for (int i = 0; i < TIMEOUT && !ok; i++) begin
      if (rx_if.READY) ok = 1'b1;
      step();
    end
    rx_if.VALID = 1'b0;
    n_total++;
    if (!ok) $display("FAIL accept_timeout: got no accept, expected accept within %0d cycles", TIMEOUT);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_total++;
    if ({rx_if.READY, s0_if.VALID, s1_if.VALID} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {rx_if.READY, s0_if.VALID, s1_if.VALID});
    else n_pass++;
    n_total++;
    if (s0_if.DATA !== pkt_t'(0) || s1_if.DATA !== pkt_t'(0))
      $display("FAIL reset_data: got %0h/%0h expected 0", s0_if.DATA, s1_if.DATA);
    else n_pass++;
    rst = 1'b0;
    step();
    step();
    n_total++;
    if ({rx_if.READY, s0_if.VALID, s1_if.VALID} !== 3'b000)
      $display("FAIL idle_ctrl: got %b expected 000", {rx_if.READY, s0_if.VALID, s1_if.VALID});
    else n_pass++;
  endtask

  // Output 0 only, READY tied high: handshake at E+2, next accept at E+4.
  task automatic test_single_out0();
    int   b0, b1, a, v1;
    pkt_t p, q;
    s0_if.READY = 1'b1;
    s1_if.READY = 1'b1;
    b0 = obs0_q.size(); b1 = obs1_q.size(); a = acc_edge.size(); v1 = vld1_cycles;
    p = rand_pkt(DEST_OUT0);
    p[7:2] = 6'b101001;
    q = rand_pkt(DEST_OUT0);
    send_pkt(p);
    send_pkt(q);
    repeat (6) step();
    n_total++;
    if (obs0_q.size() != b0 + 2) $display("FAIL out0_count: got %0d expected %0d", obs0_q.size() - b0, 2);
    else n_pass++;
    if (obs0_q.size() >= b0 + 2 && acc_edge.size() >= a + 2) begin
      n_total++;
      if (obs0_q[b0] !== p) $display("FAIL out0_data: got %0h expected %0h", obs0_q[b0], p);
      else n_pass++;
      n_total++;
      if (obs0_edge[b0] != acc_edge[a] + 2)
        $display("FAIL out0_latency: got %0d expected %0d", obs0_edge[b0] - acc_edge[a], 2);
      else n_pass++;
      n_total++;
      if (acc_edge[a + 1] != acc_edge[a] + 4)
        $display("FAIL accept_gap: got %0d expected %0d", acc_edge[a + 1] - acc_edge[a], 4);
      else n_pass++;
      n_total++;
      if (obs0_q[b0 + 1] !== q) $display("FAIL out0_data2: got %0h expected %0h", obs0_q[b0 + 1], q);
      else n_pass++;
    end
    n_total++;
    if (obs1_q.size() != b1 || vld1_cycles != v1)
      $display("FAIL out1_quiet: got %0d valid cycles expected 0", vld1_cycles - v1);
    else n_pass++;
  endtask

  // Broadcast with output 1 stalled five cycles after its VALID rises.
  task automatic test_bcast_skew();
    int   b0, b1, a;
    bit   found, bad;
    pkt_t p, q;
`ifdef PACKET_DISPATCH_STAT_EN
    logic [31:0] c0, c1;
    c0 = sent0_count; c1 = sent1_count;
`endif
    s0_if.READY = 1'b1;
    s1_if.READY = 1'b0;
    b0 = obs0_q.size(); b1 = obs1_q.size(); a = acc_edge.size();
    p = rand_pkt(DEST_BCAST);
    q = rand_pkt(DEST_OUT0);
    send_pkt(p);
    found = 1'b0;
    for (int i = 0; i < TIMEOUT && !found; i++) begin
      if (s1_if.VALID) found = 1'b1;
      else step();
    end
    n_total++;
    if (!found) $display("FAIL bcast_valid1: got no VALID expected VALID within %0d cycles", TIMEOUT);
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!s1_if.VALID || rx_if.READY) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL bcast_hold: got VALID1 drop or early READY expected VALID1 held, READY 0");
    else n_pass++;
    s1_if.READY = 1'b1;
    send_pkt(q);
    repeat (6) step();
    n_total++;
    if (obs0_q.size() != b0 + 2 || obs1_q.size() != b1 + 1 || acc_edge.size() != a + 2)
      $display("FAIL bcast_count: got %0d/%0d/%0d expected 2/1/2",
               obs0_q.size() - b0, obs1_q.size() - b1, acc_edge.size() - a);
    else begin
      n_pass++;
      n_total++;
      if (obs0_q[b0] !== p || obs1_q[b1] !== p || obs0_q[b0 + 1] !== q)
        $display("FAIL bcast_data: got %0h/%0h expected %0h", obs0_q[b0], obs1_q[b1], p);
      else n_pass++;
      n_total++;
      if (obs0_edge[b0] != acc_edge[a] + 2 || obs1_edge[b1] != acc_edge[a] + 7)
        $display("FAIL bcast_timing: got +%0d/+%0d expected +2/+7",
                 obs0_edge[b0] - acc_edge[a], obs1_edge[b1] - acc_edge[a]);
      else n_pass++;
      n_total++;
      if (acc_edge[a + 1] != obs1_edge[b1] + 2)
        $display("FAIL bcast_next_accept: got +%0d expected +2", acc_edge[a + 1] - obs1_edge[b1]);
      else n_pass++;
    end
`ifdef PACKET_DISPATCH_STAT_EN
    n_total++;
    if (sent0_count - c0 != 32'd2 || sent1_count - c1 != 32'd1)
      $display("FAIL bcast_stats: got %0d/%0d expected 2/1", sent0_count - c0, sent1_count - c1);
    else n_pass++;
`endif
  endtask

  // A dropped packet is accepted but never offered; the next one goes to output 1.
  task automatic test_drop();
    int   b0, b1, a, v0;
    pkt_t p, q;
`ifdef PACKET_DISPATCH_STAT_EN
    logic [31:0] cd;
    cd = drop_count;
`endif
    s0_if.READY = 1'b1;
    s1_if.READY = 1'b1;
    b0 = obs0_q.size(); b1 = obs1_q.size(); a = acc_edge.size(); v0 = vld0_cycles;
    p = rand_pkt(DEST_DROP);
    q = rand_pkt(DEST_OUT1);
    send_pkt(p);
    send_pkt(q);
    repeat (6) step();
    n_total++;
    if (obs0_q.size() != b0 || vld0_cycles != v0)
      $display("FAIL drop_out0: got %0d valid cycles expected 0", vld0_cycles - v0);
    else n_pass++;
    n_total++;
    if (obs1_q.size() != b1 + 1) $display("FAIL drop_out1_count: got %0d expected 1", obs1_q.size() - b1);
    else begin
      n_pass++;
      n_total++;
      if (obs1_q[b1] !== q) $display("FAIL drop_out1_data: got %0h expected %0h", obs1_q[b1], q);
      else n_pass++;
    end
    n_total++;
    if (acc_edge.size() != a + 2) $display("FAIL drop_accepts: got %0d expected 2", acc_edge.size() - a);
    else begin
      n_pass++;
      n_total++;
      if (acc_edge[a + 1] != acc_edge[a] + 2)
        $display("FAIL drop_gap: got %0d expected 2", acc_edge[a + 1] - acc_edge[a]);
      else n_pass++;
    end
`ifdef PACKET_DISPATCH_STAT_EN
    n_total++;
    if (drop_count - cd != 32'd1) $display("FAIL drop_stat: got %0d expected 1", drop_count - cd);
    else n_pass++;
`endif
  endtask

  // Streams n packets under random downstream READY and scores both outputs in order.
  task automatic run_stream(input int n, input bit alternate, input string tag);
    pkt_t exp0[$], exp1[$];
    int   b0, b1;
    logic [1:0] dest;
    pkt_t p;
    b0 = obs0_q.size(); b1 = obs1_q.size();
    rand_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      dest = alternate ? 2'(i % 2) : 2'($urandom_range(0, 3));
      p = rand_pkt(dest);
      if (dest == DEST_OUT0 || dest == DEST_BCAST) exp0.push_back(p);
      if (dest == DEST_OUT1 || dest == DEST_BCAST) exp1.push_back(p);
      send_pkt(p);
    end
    for (int i = 0; i < TIMEOUT * 4 &&
         (obs0_q.size() < b0 + exp0.size() || obs1_q.size() < b1 + exp1.size()); i++) step();
    rand_rdy = 1'b0;
    s0_if.READY = 1'b1;
    s1_if.READY = 1'b1;
    repeat (8) step();
    n_total++;
    if (obs0_q.size() - b0 != exp0.size() || obs1_q.size() - b1 != exp1.size())
      $display("FAIL %s_count: got %0d/%0d expected %0d/%0d", tag,
               obs0_q.size() - b0, obs1_q.size() - b1, exp0.size(), exp1.size());
    else begin
      n_pass++;
      foreach (exp0[i]) begin
        n_total++;
        if (obs0_q[b0 + i] !== exp0[i])
          $display("FAIL %s_out0[%0d]: got %0h expected %0h", tag, i, obs0_q[b0 + i], exp0[i]);
        else n_pass++;
      end
      foreach (exp1[i]) begin
        n_total++;
        if (obs1_q[b1 + i] !== exp1[i])
          $display("FAIL %s_out1[%0d]: got %0h expected %0h", tag, i, obs1_q[b1 + i], exp1[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    run_stream(16, 1'b1, "b2b");
  endtask

  task automatic test_random_mix();
    run_stream(24, 1'b0, "mix");
  endtask

  // Reset while output 0 is offering: everything clears and the packet is lost.
  task automatic test_reset_mid();
    int   b0;
    bit   found;
    pkt_t p;
    s0_if.READY = 1'b0;
    s1_if.READY = 1'b0;
    b0 = obs0_q.size();
    p = rand_pkt(DEST_OUT0);
    send_pkt(p);
    found = 1'b0;
    for (int i = 0; i < TIMEOUT && !found; i++) begin
      if (s0_if.VALID) found = 1'b1;
      else step();
    end
    n_total++;
    if (!found) $display("FAIL rst_mid_valid0: got no VALID expected VALID within %0d cycles", TIMEOUT);
    else n_pass++;
    rst = 1'b1;
    step();
    n_total++;
    if ({rx_if.READY, s0_if.VALID, s1_if.VALID} !== 3'b000)
      $display("FAIL rst_mid_ctrl: got %b expected 000", {rx_if.READY, s0_if.VALID, s1_if.VALID});
    else n_pass++;
    n_total++;
    if (s0_if.DATA !== pkt_t'(0) || s1_if.DATA !== pkt_t'(0))
      $display("FAIL rst_mid_data: got %0h/%0h expected 0", s0_if.DATA, s1_if.DATA);
    else n_pass++;
    rst = 1'b0;
    s0_if.READY = 1'b1;
    repeat (10) step();
    n_total++;
    if (obs0_q.size() != b0 || s0_if.VALID !== 1'b0)
      $display("FAIL rst_mid_resend: got %0d sends expected 0", obs0_q.size() - b0);
    else n_pass++;
`ifdef PACKET_DISPATCH_STAT_EN
    n_total++;
    if (sent0_count !== 32'd0 || sent1_count !== 32'd0 || drop_count !== 32'd0)
      $display("FAIL rst_mid_stats: got %0d/%0d/%0d expected 0/0/0", sent0_count, sent1_count, drop_count);
    else n_pass++;
`endif
  endtask

`ifdef PACKET_DISPATCH_STAT_EN
  task automatic test_stat_wrap();
    logic [31:0] c1;
    s0_if.READY = 1'b1;
    s1_if.READY = 1'b1;
    force dut.sent0_count_q = 32'hFFFF_FFFF;
    step();
    release dut.sent0_count_q;
    step();
    c1 = sent1_count;
    send_pkt(rand_pkt(DEST_OUT0));
    repeat (6) step();
    n_total++;
    if (sent0_count !== 32'd0 || sent1_count !== c1)
      $display("FAIL stat_wrap: got %0h/%0h expected 0/%0h", sent0_count, sent1_count, c1);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx_if.VALID = 1'b0;
    rx_if.DATA  = '0;
    s0_if.READY = 1'b0;
    s1_if.READY = 1'b0;
    test_reset();
    test_single_out0();
    test_bcast_skew();
    test_drop();
    test_back_to_back();
    test_random_mix();
    test_reset_mid();
`ifdef PACKET_DISPATCH_STAT_EN
    test_stat_wrap();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
